// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-fetch and load/store requests onto the
// single data port of the unified memory. One access is in flight at a time.
// Each access is sequenced IDLE -> ACCESS -> RESP. LS normally wins a
// conflict, but a starvation counter periodically hands the port to IF.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4      // LS wins in a row while IF waits; 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction fetch requester
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_addr,
    output logic        if_resp_valid,
    input  logic        if_resp_ready,
    output logic [31:0] if_resp_instr,
    // load/store requester
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic        ls_wr,
    input  logic [7:0]  ls_strb,
    input  logic [63:0] ls_addr,
    input  logic [63:0] ls_wdata,
    output logic        ls_resp_valid,
    input  logic        ls_resp_ready,
    output logic [63:0] ls_resp_rdata,
    // memory data port
    output logic        mem_en,
    output logic        mem_wr,
    output logic [7:0]  mem_strb,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_reg,    state_next;
    logic        owner_ls_reg, owner_ls_next;   // 1 = LS owns the access, 0 = IF
    logic        wr_reg,       wr_next;
    logic [7:0]  strb_reg,     strb_next;
    logic [63:0] addr_reg,     addr_next;
    logic [63:0] wdata_reg,    wdata_next;
    logic [63:0] rdata_reg,    rdata_next;
    logic [3:0]  starve_reg,   starve_next;

    logic        grant_ls;
    logic        grant_if;
    logic [63:0] rdata_masked;

    // LS wins a conflict unless IF has already been passed over LIMIT times.
    assign grant_ls = ls_req_valid && !(if_req_valid && (starve_reg == LIMIT));
    assign grant_if = if_req_valid && !grant_ls;

    // Keep only the enabled bytes of a load; a store always returns zero, so the
    // response is clean even if the memory drives stray read data.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rdata_mask
            assign rdata_masked[gi*8 +: 8] =
                (strb_reg[gi] && !wr_reg) ? mem_rdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    assign if_resp_instr = rdata_reg[31:0];
    assign ls_resp_rdata = rdata_reg;

    // State and latched transaction registers; reset drops any work in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            owner_ls_reg <= 1'b0;
            wr_reg       <= 1'b0;
            strb_reg     <= 8'h00;
            addr_reg     <= 64'd0;
            wdata_reg    <= 64'd0;
            rdata_reg    <= 64'd0;
            starve_reg   <= 4'd0;
        end else begin
            state_reg    <= state_next;
            owner_ls_reg <= owner_ls_next;
            wr_reg       <= wr_next;
            strb_reg     <= strb_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            rdata_reg    <= rdata_next;
            starve_reg   <= starve_next;
        end
    end

    // Next-state, grant, memory-drive and response-valid logic.
    always_comb begin
        state_next    = state_reg;
        owner_ls_next = owner_ls_reg;
        wr_next       = wr_reg;
        strb_next     = strb_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        rdata_next    = rdata_reg;
        starve_next   = starve_reg;

        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        if_resp_valid = 1'b0;
        ls_resp_valid = 1'b0;
        mem_en        = 1'b0;
        mem_wr        = 1'b0;
        mem_strb      = 8'h00;
        mem_addr      = 64'd0;
        mem_wdata     = 64'd0;

        case (state_reg)
            ST_IDLE: begin
                if_req_ready = grant_if;
                ls_req_ready = grant_ls;
                if (grant_ls) begin
                    owner_ls_next = 1'b1;
                    wr_next       = ls_wr;
                    strb_next     = ls_strb;
                    addr_next     = ls_addr;
                    wdata_next    = ls_wdata;
                    state_next    = ST_ACCESS;
                    // Count only grants that actually made IF wait.
                    if (if_req_valid && (starve_reg < LIMIT)) begin
                        starve_next = starve_reg + 4'd1;
                    end
                end else if (grant_if) begin
                    owner_ls_next = 1'b0;
                    wr_next       = 1'b0;
                    strb_next     = 8'h0F;
                    addr_next     = if_addr;
                    wdata_next    = 64'd0;
                    starve_next   = 4'd0;
                    state_next    = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                mem_en     = 1'b1;
                mem_wr     = wr_reg;
                mem_strb   = strb_reg;
                mem_addr   = addr_reg;
                mem_wdata  = wdata_reg;
                rdata_next = rdata_masked;
                state_next = ST_RESP;
            end

            ST_RESP: begin
                if_resp_valid = !owner_ls_reg;
                ls_resp_valid = owner_ls_reg;
                if (owner_ls_reg ? ls_resp_ready : if_resp_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the unified byte-addressed memory's data port in the multi-cycle core. Instruction fetch (IF) and load/store (LS) requests arrive on valid/ready handshakes. The block grants one at a time and drives a single memory access. It returns the result on a per-requester valid/ready response channel. LS has priority, with a starvation guard for IF.

## Interface
- STARVE_LIMIT, 4: consecutive LS grants taken while IF is pending before IF is forced to win; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req_valid  in  1  IF request.
- if_req_ready  out  1  IF request accepted this cycle.
- if_addr  in  64  fetch byte address.
- if_resp_valid  out  1  IF response valid.
- if_resp_ready  in  1  IF response consumed.
- if_resp_instr  out  32  fetched instruction.
- ls_req_valid  in  1  LS request.
- ls_req_ready  out  1  LS request accepted.
- ls_wr  in  1  1 = store, 0 = load.
- ls_strb  in  8  byte enables.
- ls_addr  in  64  byte address.
- ls_wdata  in  64  store data.
- ls_resp_valid  out  1  LS response valid.
- ls_resp_ready  in  1  LS response consumed.
- ls_resp_rdata  out  64  load data, strobe-masked; 0 for stores.
- mem_en, mem_wr  out  1 each  memory enable / write.
- mem_strb  out  8  memory byte enables.
- mem_addr  out  64  memory address.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data: combinational, masked by mem_strb, 0 unless en && !wr.

## Operation
- FSM has three states:
  - IDLE: grant is combinational. Only the winner sees ready=1. When valid && ready, latch the request fields and owner, then go to ACCESS.
  - ACCESS: drive mem_* from the latched fields for exactly one cycle. Capture mem_rdata into the response register, then go to RESP.
  - RESP: assert the owner's resp_valid. When the owner's resp_ready is high, go to IDLE.
- IF access uses mem_wr=0, mem_strb=8'h0F, mem_addr=if_addr, and mem_wdata=0. if_resp_instr = captured rdata[31:0].
- LS access passes wr/strb/addr/wdata unchanged. A store produces a response with ls_resp_rdata=0 as a write acknowledge.
- Arbitration in IDLE:
  - If only one request is valid, it wins.
  - If both are valid, LS wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
- starve_cnt is 4 bits:
  - On an LS grant with if_req_valid high, it increments, saturating at STARVE_LIMIT.
  - On an IF grant, it clears to 0.
  - On an LS grant with if_req_valid low, it is unchanged.
- Outside ACCESS, all mem_* outputs are 0. The memory therefore never sees a spurious write.
- Request inputs are don't-care after acceptance. Only the latched copy is used.
- ls_strb=0 is a legal transaction: no bytes are written and a load returns 0. The full handshake still completes.
- The full 64-bit address is passed through. Truncation and wrap-around belong to the memory.
- No ready is asserted in ACCESS or RESP. Any new request waits until IDLE.

## Timing
- Reset values:
  - State: IDLE.
  - starve_cnt: 0.
  - All resp_valid, resp data, mem_en, mem_wr, mem_strb, mem_addr, mem_wdata: 0.
  - if_req_ready / ls_req_ready: combinational from IDLE and the request valids, so 0 while no request is pending.
- Request accepted at edge N. mem_en is high during cycle N+1. The store commits at edge N+2, and rdata is captured at edge N+2.
- resp_valid rises in cycle N+2 and holds, with stable data, until resp_ready.
- If resp_ready is already high in cycle N+2, the block is back in IDLE in cycle N+3 and can accept at edge N+3. Peak throughput is one access per 3 cycles.
- Back-pressure: while resp_ready is low, the block stays in RESP indefinitely. Both req_ready outputs stay 0.
- Reset asserted mid-operation forces IDLE immediately, asynchronously:
  - A latched but unissued transaction is dropped.
  - A store is not performed if rst_n is low at the ACCESS-ending edge.
  - Pending responses are discarded.
- The winner is decided from same-cycle valids. A requester that drops valid before ready is not granted.

## Test plan
- Single IF: preload mem[0x100..0x103] = 13 05 00 00, then fetch 0x100 -> if_req_ready at N, mem_en/strb=0x0F at N+1, if_resp_instr=32'h0000_0513 at N+2.
- LS store then load:
  - Store addr 0x200, strb 0xFF, wdata 64'h1122_3344_5566_7788 -> ack rdata=0.
  - Load addr 0x200, strb 0x0F -> ls_resp_rdata=64'h0000_0000_5566_7788.
- Simultaneous requests with STARVE_LIMIT=4 and both valid continuously -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF. starve_cnt is 0 after each IF grant.
- Response back-pressure: hold ls_resp_ready=0 for 5 cycles -> ls_resp_valid and ls_resp_rdata stable, both req_ready=0, mem_en=0. Release -> IDLE next cycle.
- Reset during ACCESS of a store to 0x300 (wdata all-ones) -> outputs all 0 immediately. A later load of 0x300 returns the old contents.
- Store with strb=0 -> ack returned, memory unchanged, 3-cycle latency preserved.
